// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory-access stage: op and
// load-extension encodings, access sizes and the sequencer state type.
package mem_pkg;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  localparam logic [2:0] LDS_W  = 3'b000;
  localparam logic [2:0] LDS_H  = 3'b001;
  localparam logic [2:0] LDS_B  = 3'b010;
  localparam logic [2:0] LDS_BU = 3'b011;
  localparam logic [2:0] LDS_HU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B    = 2'd0,
    SZ_H    = 2'd1,
    SZ_W    = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  function automatic size_e op_size(input logic [3:0] op);
    size_e r;
    case (op)
      OP_LB, OP_LBU, OP_SB: r = SZ_B;
      OP_LH, OP_LHU, OP_SH: r = SZ_H;
      OP_LW, OP_SW:         r = SZ_W;
      default:              r = SZ_NONE;
    endcase
    return r;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic r;
    case (op_size(op))
      SZ_H:    r = off[0];
      SZ_W:    r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and data replication, and load
// extraction of the addressed byte/half down to bit 0.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_ld_data,
  output logic [2:0]  o_ld_sel,
  output logic        o_ld_sign
);

  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;

  assign w_rd_byte = 8'(i_rdata >> {i_offset, 3'b000});
  assign w_rd_half = 16'(i_rdata >> {i_offset[1], 4'b0000});

  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = 32'h0000_0000;
    o_ld_data   = 32'h0000_0000;
    case (op_size(i_op))
      SZ_B: begin
        o_be        = 4'b0001 << i_offset;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_ld_data   = {24'h00_0000, w_rd_byte};
      end
      SZ_H: begin
        o_be        = i_offset[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_ld_data   = {16'h0000, w_rd_half};
      end
      SZ_W: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_ld_data   = i_rdata;
      end
      default: begin
        o_be        = 4'b0000;
        o_wdata_rep = 32'h0000_0000;
        o_ld_data   = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    o_ld_sel  = LDS_W;
    o_ld_sign = 1'b0;
    case (i_op)
      OP_LB:   begin o_ld_sel = LDS_B;  o_ld_sign = 1'b1; end
      OP_LBU:  begin o_ld_sel = LDS_BU; o_ld_sign = 1'b0; end
      OP_LH:   begin o_ld_sel = LDS_H;  o_ld_sign = 1'b1; end
      OP_LHU:  begin o_ld_sel = LDS_HU; o_ld_sign = 1'b0; end
      default: begin o_ld_sel = LDS_W;  o_ld_sign = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store sequencer: issues one data-memory request per op,
// waits for the ack (with timeout), and returns aligned load data.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ld_data,
  output logic [2:0]  ld_sel,
  output logic        ld_sign,
  output logic        ld_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] bad_addr
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_e        r_state;
  logic [CW-1:0] r_wait;
  logic [3:0]    r_op;
  logic [31:0]   r_addr;

  logic          w_idle;
  logic          w_op_ok;
  logic          w_misal;
  logic          w_accept;
  logic [3:0]    w_al_op;
  logic [1:0]    w_al_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic [31:0]   w_ld_data;
  logic [2:0]    w_ld_sel;
  logic          w_ld_sign;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_op_ok  = (op_size(op) != SZ_NONE);
  assign w_misal  = op_misaligned(op, addr[1:0]);
  assign w_accept = w_idle & valid_in & w_op_ok & ~w_misal;

  // In IDLE the aligner steers the incoming store; afterwards it extracts the held load.
  assign w_al_op  = w_idle ? op : r_op;
  assign w_al_off = w_idle ? addr[1:0] : r_addr[1:0];

  lsu_lane_align u_lane_align (
    .i_op        (w_al_op),
    .i_offset    (w_al_off),
    .i_wdata     (wdata),
    .i_rdata     (dmem_rdata),
    .o_be        (w_be),
    .o_wdata_rep (w_wdata_rep),
    .o_ld_data   (w_ld_data),
    .o_ld_sel    (w_ld_sel),
    .o_ld_sign   (w_ld_sign)
  );

  assign stall = rst_n & (w_accept | (r_state == ST_ACCESS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait     <= '0;
      r_op       <= 4'h0;
      r_addr     <= 32'h0000_0000;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      ld_data    <= 32'h0000_0000;
      ld_sel     <= 3'b000;
      ld_sign    <= 1'b0;
      ld_valid   <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      bad_addr   <= 32'h0000_0000;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      ld_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_ACCESS;
            r_wait     <= '0;
            r_op       <= op;
            r_addr     <= addr;
            dmem_req   <= 1'b1;
            dmem_we    <= op_is_store(op);
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata_rep;
          end else if (valid_in & w_op_ok & w_misal) begin
            misalign <= 1'b1;
            bad_addr <= addr;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            r_state  <= ST_RESP;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!op_is_store(r_op)) begin
              ld_valid <= 1'b1;
              ld_data  <= w_ld_data;
              ld_sel   <= w_ld_sel;
              ld_sign  <= w_ld_sign;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_state  <= ST_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            bus_err  <= 1'b1;
            bad_addr <= r_addr;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// accesses compared against a byte-level behavioural model.
module tb_mem_access;
  import mem_pkg::*;

  localparam int MW = 15;

  logic        clk, rst_n, valid_in;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ld_data;
  logic [2:0]  ld_sel;
  logic        ld_sign, ld_valid, misalign, bus_err;
  logic [31:0] bad_addr;
  logic [141:0] all_out;

  int total = 0;
  int bad   = 0;

  // observations from the most recent access
  int o_stall, o_req, o_unstable, o_ldv, o_ldv_cyc, o_mis, o_mis_cyc, o_berr, o_berr_cyc;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_daddr, o_dwd, o_ld, o_bad;
  logic [2:0]  o_sel;
  logic        o_sign;
  logic [31:0] m_last_ld;

  mem_access #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .addr(addr), .wdata(wdata),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .ld_data(ld_data), .ld_sel(ld_sel), .ld_sign(ld_sign), .ld_valid(ld_valid),
    .misalign(misalign), .bus_err(bus_err), .bad_addr(bad_addr)
  );

  assign all_out = {stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ld_data,
                    ld_sel, ld_sign, ld_valid, misalign, bus_err, bad_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [3:0] o);
    if (o == OP_LB || o == OP_LBU || o == OP_SB) return 1;
    if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_st(input logic [3:0] o);
    return (o == OP_SB || o == OP_SH || o == OP_SW);
  endfunction

  function automatic bit m_aligned(input logic [3:0] o, input logic [31:0] a);
    return (a % sz_of(o)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] o, input logic [31:0] a);
    logic [3:0] r;
    int s, off;
    s = sz_of(o);
    off = a % 4;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + s) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wrep(input logic [3:0] o, input logic [31:0] w);
    logic [31:0] r;
    int s;
    s = sz_of(o);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ld(input logic [3:0] o, input logic [31:0] a, input logic [31:0] rd);
    longint unsigned v, mask;
    v = rd;
    v = v >> (8 * (a % 4));
    mask = (64'd1 << (8 * sz_of(o))) - 64'd1;
    return 32'(v & mask);
  endfunction

  function automatic logic [3:0] m_selsign(input logic [3:0] o);
    if (o == OP_LB)  return 4'b010_1;
    if (o == OP_LBU) return 4'b011_0;
    if (o == OP_LH)  return 4'b001_1;
    if (o == OP_LHU) return 4'b100_0;
    return 4'b000_0;
  endfunction

  // ---------------- stimulus driver (observes, does not judge) ----------------
  task automatic run_access(input logic [3:0] aop, input logic [31:0] aaddr, input logic [31:0] awd,
                            input logic [31:0] ard, input int ack_at, input int ncyc);
    o_stall = 0; o_req = 0; o_unstable = 0; o_ldv = 0; o_ldv_cyc = -1;
    o_mis = 0; o_mis_cyc = -1; o_berr = 0; o_berr_cyc = -1;
    @(negedge clk);
    valid_in = 1'b1; op = aop; addr = aaddr; wdata = awd;
    for (int c = 0; c < ncyc; c++) begin
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? ard : $urandom();
      #1;
      if (stall) o_stall++;
      if (dmem_req) begin
        if (o_req == 0) begin
          o_be = dmem_be; o_dwd = dmem_wdata; o_we = dmem_we; o_daddr = dmem_addr;
        end else if ({dmem_be, dmem_wdata, dmem_we, dmem_addr} !== {o_be, o_dwd, o_we, o_daddr}) begin
          o_unstable++;
        end
        o_req++;
      end
      if (ld_valid) begin
        o_ldv++;
        if (o_ldv_cyc < 0) o_ldv_cyc = c;
        o_ld = ld_data; o_sel = ld_sel; o_sign = ld_sign;
      end
      if (misalign) begin
        o_mis++;
        if (o_mis_cyc < 0) o_mis_cyc = c;
        o_bad = bad_addr;
      end
      if (bus_err) begin
        o_berr++;
        if (o_berr_cyc < 0) o_berr_cyc = c;
        o_bad = bad_addr;
      end
      @(negedge clk);
      valid_in = 1'b0;
      op = 4'($urandom()); addr = $urandom(); wdata = $urandom();
    end
    dmem_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; valid_in = 1'b1; op = OP_LW; addr = 32'h0000_0100; wdata = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #12;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(negedge clk);
    valid_in = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", all_out); end
    m_last_ld = 32'h0;
  endtask

  task automatic test_lb_basic;
    run_access(OP_LB, 32'h0000_1003, 32'h5555_5555, 32'h80FF_0000, 1, 4);
    total++;
    if (o_ldv_cyc !== 2 || o_ldv !== 1) begin bad++; $display("FAIL lb_latency got_cyc=%0d got_cnt=%0d exp_cyc=2 exp_cnt=1", o_ldv_cyc, o_ldv); end
    total++;
    if (o_ld !== 32'h0000_0080) begin bad++; $display("FAIL lb_data got=%h exp=00000080", o_ld); end
    total++;
    if ({o_sel, o_sign} !== 4'b010_1) begin bad++; $display("FAIL lb_selsign got=%b exp=0101", {o_sel, o_sign}); end
    total++;
    if (o_be !== 4'b1000 || o_we !== 1'b0 || o_daddr !== 32'h0000_1000) begin
      bad++; $display("FAIL lb_req got_be=%b we=%b addr=%h exp_be=1000 we=0 addr=00001000", o_be, o_we, o_daddr);
    end
    m_last_ld = 32'h0000_0080;
  endtask

  task automatic test_sh_store;
    run_access(OP_SH, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 1, 4);
    total++;
    if (o_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", o_be); end
    total++;
    if (o_dwd !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o_dwd); end
    total++;
    if (o_we !== 1'b1 || o_req !== 1) begin bad++; $display("FAIL sh_we got_we=%b req_cycles=%0d exp_we=1 req_cycles=1", o_we, o_req); end
    total++;
    if (o_ldv !== 0 || ld_data !== m_last_ld) begin bad++; $display("FAIL sh_no_load got_ldv=%0d ld_data=%h exp_ldv=0 ld_data=%h", o_ldv, ld_data, m_last_ld); end
  endtask

  task automatic test_misalign;
    run_access(OP_LW, 32'h0000_0006, 32'h0, 32'h0, -1, 3);
    total++;
    if (o_mis !== 1 || o_mis_cyc !== 1) begin bad++; $display("FAIL misalign_pulse got_cnt=%0d cyc=%0d exp_cnt=1 cyc=1", o_mis, o_mis_cyc); end
    total++;
    if (o_bad !== 32'h0000_0006) begin bad++; $display("FAIL misalign_bad_addr got=%h exp=00000006", o_bad); end
    total++;
    if (o_req !== 0 || o_stall !== 0) begin bad++; $display("FAIL misalign_noreq got_req=%0d stall=%0d exp=0 0", o_req, o_stall); end
  endtask

  task automatic test_lhu_wait;
    run_access(OP_LHU, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 5, 8);
    total++;
    if (o_stall !== 6) begin bad++; $display("FAIL lhu_stall got=%0d exp=6", o_stall); end
    total++;
    if (o_ld !== 32'h0000_BEEF || o_sel !== 3'b100 || o_sign !== 1'b0) begin
      bad++; $display("FAIL lhu_data got=%h sel=%b sign=%b exp=0000beef sel=100 sign=0", o_ld, o_sel, o_sign);
    end
    total++;
    if (o_ldv_cyc !== 6 || o_req !== 5) begin bad++; $display("FAIL lhu_timing got_ldv_cyc=%0d req=%0d exp=6 5", o_ldv_cyc, o_req); end
    m_last_ld = 32'h0000_BEEF;
  endtask

  task automatic test_bus_err;
    run_access(OP_LW, 32'h0000_3010, 32'h0, 32'h0, -1, MW + 3);
    total++;
    if (o_berr !== 1 || o_berr_cyc !== MW + 1) begin bad++; $display("FAIL buserr_pulse got_cnt=%0d cyc=%0d exp_cnt=1 cyc=%0d", o_berr, o_berr_cyc, MW + 1); end
    total++;
    if (o_stall !== MW + 1 || o_req !== MW) begin bad++; $display("FAIL buserr_stall got_stall=%0d req=%0d exp=%0d %0d", o_stall, o_req, MW + 1, MW); end
    total++;
    if (o_bad !== 32'h0000_3010 || o_ldv !== 0) begin bad++; $display("FAIL buserr_addr got=%h ldv=%0d exp=00003010 0", o_bad, o_ldv); end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (ld_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0 || ld_data !== m_last_ld) begin
      bad++; $display("FAIL buserr_late_ack got_ldv=%b req=%b stall=%b ld=%h exp=0 0 0 %h", ld_valid, dmem_req, stall, ld_data, m_last_ld);
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    valid_in = 1'b1; op = OP_LW; addr = 32'h0000_0040; wdata = 32'h0;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (dmem_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre_req got=%b exp=1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL rstmid_outputs got=%h exp=0", all_out); end
    @(negedge clk);
    rst_n = 1'b1;
    m_last_ld = 32'h0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total++;
    if (ld_valid !== 1'b0 || dmem_req !== 1'b0 || ld_data !== 32'h0) begin
      bad++; $display("FAIL rstmid_late_ack got_ldv=%b req=%b ld=%h exp=0 0 0", ld_valid, dmem_req, ld_data);
    end
    run_access(OP_LW, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 2, 5);
    total++;
    if (o_ldv !== 1 || o_ld !== 32'h1357_9BDF || o_ldv_cyc !== 3) begin
      bad++; $display("FAIL rstmid_followup got_ldv=%0d ld=%h cyc=%0d exp=1 13579bdf 3", o_ldv, o_ld, o_ldv_cyc);
    end
    m_last_ld = 32'h1357_9BDF;
  endtask

  task automatic test_random;
    logic [3:0]  ops [8];
    logic [3:0]  ro;
    logic [31:0] ra, rw, rr;
    int          s, ack;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    for (int it = 0; it < 40; it++) begin
      ro = ops[$urandom_range(7, 0)];
      s  = sz_of(ro);
      ra = $urandom();
      if ($urandom_range(3, 0) != 0) ra = ra - (ra % s);
      rw = $urandom();
      rr = $urandom();
      ack = (it % 10 == 9) ? MW : $urandom_range(6, 1);
      if (!m_aligned(ro, ra)) begin
        run_access(ro, ra, rw, rr, -1, 3);
        total++;
        if (o_mis !== 1 || o_mis_cyc !== 1 || o_bad !== ra || o_req !== 0 || o_stall !== 0) begin
          bad++; $display("FAIL rnd_misalign it=%0d got_mis=%0d cyc=%0d bad=%h req=%0d stall=%0d exp=1 1 %h 0 0",
                          it, o_mis, o_mis_cyc, o_bad, o_req, o_stall, ra);
        end
      end else begin
        run_access(ro, ra, rw, rr, ack, ack + 3);
        total++;
        if (o_stall !== ack + 1 || o_req !== ack || o_unstable !== 0 || o_mis !== 0 || o_berr !== 0) begin
          bad++; $display("FAIL rnd_handshake it=%0d got_stall=%0d req=%0d unstable=%0d mis=%0d berr=%0d exp=%0d %0d 0 0 0",
                          it, o_stall, o_req, o_unstable, o_mis, o_berr, ack + 1, ack);
        end
        total++;
        if (o_be !== m_be(ro, ra) || o_daddr !== (ra - (ra % 4)) || o_we !== is_st(ro)) begin
          bad++; $display("FAIL rnd_request it=%0d got_be=%b addr=%h we=%b exp=%b %h %b",
                          it, o_be, o_daddr, o_we, m_be(ro, ra), ra - (ra % 4), is_st(ro));
        end
        if (is_st(ro)) begin
          total++;
          if (o_dwd !== m_wrep(ro, rw) || o_ldv !== 0) begin
            bad++; $display("FAIL rnd_store it=%0d got_wdata=%h ldv=%0d exp=%h 0", it, o_dwd, o_ldv, m_wrep(ro, rw));
          end
        end else begin
          total++;
          if (o_ldv !== 1 || o_ldv_cyc !== ack + 1 || o_ld !== m_ld(ro, ra, rr) || {o_sel, o_sign} !== m_selsign(ro)) begin
            bad++; $display("FAIL rnd_load it=%0d got_ldv=%0d cyc=%0d data=%h selsign=%b exp=1 %0d %h %b",
                            it, o_ldv, o_ldv_cyc, o_ld, {o_sel, o_sign}, ack + 1, m_ld(ro, ra, rr), m_selsign(ro));
          end
          m_last_ld = m_ld(ro, ra, rr);
        end
      end
      total++;
      if (ld_data !== m_last_ld) begin bad++; $display("FAIL rnd_ld_hold it=%0d got=%h exp=%h", it, ld_data, m_last_ld); end
    end
  endtask

  initial begin
    test_reset();
    test_lb_basic();
    test_sh_store();
    test_misalign();
    test_lhu_wait();
    test_bus_err();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
